gpu_framebuffer: RTL and testbench

//  Double-buffered 160x120 RGB555+T framebuffer directly downstream of the GPU draw engine.
//  - Accepts the GPU pixel-write stream (fb_x/fb_y/fb_color/fb_write) into the back buffer.
//  - Serves pixel reads for video scanout from the front buffer.
//  - Swaps front and back on request, synchronised to the display's vblank so no frame tears.

---
 rtl/gpu_framebuffer_pkg.sv | 24 ++
 rtl/gpu_framebuffer_fb_bram.sv | 26 ++
 rtl/gpu_framebuffer.sv | 151 +++++++++++++++
 tb/tb_gpu_framebuffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_framebuffer_pkg.sv
// rtl/gpu_framebuffer_pkg.sv - framebuffer geometry, colour format and swap FSM encodings
package gpu_framebuffer_pkg;

    localparam int FB_WIDTH   = 160;
    localparam int FB_HEIGHT  = 120;
    localparam int FB_DEPTH   = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W  = 15;
    localparam int COLOR_W    = 16;
    localparam int OPAQUE_BIT = 0;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

    function automatic logic [15:0] fb_lin_addr(input logic [7:0] x, input logic [7:0] y);
        return 16'(y) * 16'(FB_WIDTH) + 16'(x);
    endfunction

    function automatic logic fb_in_range(input logic [7:0] x, input logic [7:0] y);
        return (x < 8'(FB_WIDTH)) && (y < 8'(FB_HEIGHT));
    endfunction

endpackage

// File: rtl/gpu_framebuffer_fb_bram.sv
// rtl/gpu_framebuffer_fb_bram.sv - one framebuffer: simple dual-port RAM, synchronous read
module gpu_framebuffer_fb_bram
    import gpu_framebuffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [FB_ADDR_W-1:0] waddr_i,
    input  logic [COLOR_W-1:0]   wdata_i,
    input  logic                 re_i,
    input  logic [FB_ADDR_W-1:0] raddr_i,
    output logic [COLOR_W-1:0]   rdata_o
);

    logic [COLOR_W-1:0] mem_q [FB_DEPTH];

    // Read-before-write when both ports hit the same word in one cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/gpu_framebuffer.sv
// rtl/gpu_framebuffer.sv - double-buffered 160x120 framebuffer with vblank-synchronised swap
module gpu_framebuffer
    import gpu_framebuffer_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic [7:0]         fb_x,
    input  logic [7:0]         fb_y,
    input  logic [COLOR_W-1:0] fb_color,
    input  logic               fb_write,
    input  logic               ctrl_swap,
    output logic               swap_pending,
    output logic               swap_done,
    output logic               front_sel,
    input  logic               disp_vblank,
    input  logic               disp_req,
    input  logic [7:0]         disp_x,
    input  logic [7:0]         disp_y,
    output logic [COLOR_W-1:0] disp_color,
    output logic               disp_valid
);

    swap_state_e state_q;
    logic        ctrl_swap_q, vblank_q;
    logic        front_sel_q, swap_done_q;
    logic        swap_rise, vblank_rise;

    assign swap_rise   = ctrl_swap & ~ctrl_swap_q;
    assign vblank_rise = disp_vblank & ~vblank_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= SWAP_IDLE;
            ctrl_swap_q <= 1'b0;
            vblank_q    <= 1'b0;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            ctrl_swap_q <= ctrl_swap;
            vblank_q    <= disp_vblank;
            swap_done_q <= 1'b0;
            case (state_q)
                SWAP_IDLE: begin
                    if (swap_rise) begin
                        // A request that coincides with vblank is applied at once.
                        if (vblank_rise) begin
                            front_sel_q <= ~front_sel_q;
                            swap_done_q <= 1'b1;
                        end else begin
                            state_q <= SWAP_PENDING;
                        end
                    end
                end
                SWAP_PENDING: begin
                    if (vblank_rise) begin
                        front_sel_q <= ~front_sel_q;
                        swap_done_q <= 1'b1;
                        state_q     <= SWAP_IDLE;
                    end
                end
                default: state_q <= SWAP_IDLE;
            endcase
        end
    end

    assign swap_pending = (state_q == SWAP_PENDING);
    assign swap_done    = swap_done_q;
    assign front_sel    = front_sel_q;

    logic [FB_ADDR_W-1:0] w_addr_d, w_addr_q;
    logic [COLOR_W-1:0]   w_color_q;
    logic                 w_vld_q, w_inr_q, w_tgt_q;
    logic                 we0, we1;

    assign w_addr_d = FB_ADDR_W'(fb_lin_addr(fb_x, fb_y));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_vld_q   <= 1'b0;
            w_inr_q   <= 1'b0;
            w_tgt_q   <= 1'b0;
            w_addr_q  <= '0;
            w_color_q <= '0;
        end else begin
            w_vld_q   <= fb_write;
            w_inr_q   <= fb_in_range(fb_x, fb_y);
            w_tgt_q   <= ~front_sel_q;
            w_addr_q  <= w_addr_d;
            w_color_q <= fb_color;
        end
    end

    assign we0 = rstn & w_vld_q & w_inr_q & ~w_tgt_q;
    assign we1 = rstn & w_vld_q & w_inr_q &  w_tgt_q;

    logic [FB_ADDR_W-1:0] rd_addr_d;
    logic                 rd_inr_d;
    logic                 re0, re1;
    logic                 rd_vld_q, rd_inr_q, rd_sel_q;
    logic [COLOR_W-1:0]   rdata0, rdata1;
    logic                 disp_valid_q;
    logic [COLOR_W-1:0]   disp_color_q;

    assign rd_addr_d = FB_ADDR_W'(fb_lin_addr(disp_x, disp_y));
    assign rd_inr_d  = fb_in_range(disp_x, disp_y);
    assign re0       = disp_req & rd_inr_d & ~front_sel_q;
    assign re1       = disp_req & rd_inr_d &  front_sel_q;

    // Buffer select travels with the request so a swap cannot redirect it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_vld_q     <= 1'b0;
            rd_inr_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_color_q <= '0;
        end else begin
            rd_vld_q     <= disp_req;
            rd_inr_q     <= rd_inr_d;
            rd_sel_q     <= front_sel_q;
            disp_valid_q <= rd_vld_q;
            if (rd_vld_q) begin
                disp_color_q <= rd_inr_q ? (rd_sel_q ? rdata1 : rdata0) : '0;
            end
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_color = disp_color_q;

    gpu_framebuffer_fb_bram u_fb0 (
        .clk     (clk),
        .we_i    (we0),
        .waddr_i (w_addr_q),
        .wdata_i (w_color_q),
        .re_i    (re0),
        .raddr_i (rd_addr_d),
        .rdata_o (rdata0)
    );

    gpu_framebuffer_fb_bram u_fb1 (
        .clk     (clk),
        .we_i    (we1),
        .waddr_i (w_addr_q),
        .wdata_i (w_color_q),
        .re_i    (re1),
        .raddr_i (rd_addr_d),
        .rdata_o (rdata1)
    );

endmodule

// File: tb/tb_gpu_framebuffer.sv
// tb/tb_gpu_framebuffer.sv - directed and randomized checks of gpu_framebuffer against a behavioural model
module tb_gpu_framebuffer;

    localparam int W = 160;
    localparam int H = 120;
    localparam int D = W * H;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  fb_x = '0, fb_y = '0;
    logic [15:0] fb_color = '0;
    logic        fb_write = 1'b0;
    logic        ctrl_swap = 1'b0;
    logic        swap_pending, swap_done, front_sel;
    logic        disp_vblank = 1'b0;
    logic        disp_req = 1'b0;
    logic [7:0]  disp_x = '0, disp_y = '0;
    logic [15:0] disp_color;
    logic        disp_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpu_framebuffer dut (
        .clk          (clk),
        .rstn         (rstn),
        .fb_x         (fb_x),
        .fb_y         (fb_y),
        .fb_color     (fb_color),
        .fb_write     (fb_write),
        .ctrl_swap    (ctrl_swap),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .front_sel    (front_sel),
        .disp_vblank  (disp_vblank),
        .disp_req     (disp_req),
        .disp_x       (disp_x),
        .disp_y       (disp_y),
        .disp_color   (disp_color),
        .disp_valid   (disp_valid)
    );

    // Model: two pixel arrays plus what each output must read as after every clock edge.
    bit [15:0] m_mem [2][D];
    bit        m_known [2][D];
    bit        m_front = 0, m_pending = 0, m_done = 0, m_cprev = 0, m_vprev = 0;
    bit        pw_v = 0, pw_b = 0;
    int        pw_a = 0;
    bit [15:0] pw_c = 0;
    bit        s1_v = 0, s1_known = 1;
    bit [15:0] s1_c = 0;
    bit        o_v = 0, o_known = 1;
    bit [15:0] o_c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rc, rv;
        int a;
        if (!rstn) begin
            m_front = 0; m_pending = 0; m_done = 0; m_cprev = 0; m_vprev = 0;
            pw_v = 0; s1_v = 0; o_v = 0; o_c = 0; o_known = 1;
            return;
        end
        o_v = s1_v;
        if (s1_v) begin
            o_c = s1_c;
            o_known = s1_known;
        end
        s1_v = disp_req;
        if (disp_req) begin
            if (disp_x < W && disp_y < H) begin
                a = int'(disp_y) * W + int'(disp_x);
                s1_c = m_mem[m_front][a];
                s1_known = m_known[m_front][a];
            end else begin
                s1_c = 0;
                s1_known = 1;
            end
        end
        if (pw_v) begin
            m_mem[pw_b][pw_a] = pw_c;
            m_known[pw_b][pw_a] = 1;
        end
        pw_v = fb_write && fb_x < W && fb_y < H;
        pw_b = !m_front;
        pw_a = int'(fb_y) * W + int'(fb_x);
        pw_c = fb_color;
        rc = ctrl_swap && !m_cprev;
        rv = disp_vblank && !m_vprev;
        m_done = 0;
        if (m_pending) begin
            if (rv) begin
                m_front = !m_front; m_done = 1; m_pending = 0;
            end
        end else if (rc) begin
            if (rv) begin
                m_front = !m_front; m_done = 1;
            end else begin
                m_pending = 1;
            end
        end
        m_cprev = ctrl_swap;
        m_vprev = disp_vblank;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("front_sel", front_sel, m_front);
        chk("swap_pending", swap_pending, m_pending);
        chk("swap_done", swap_done, m_done);
        chk("disp_valid", disp_valid, o_v);
        if (o_known) chk("disp_color", disp_color, o_c);
    endtask

    task automatic wr(input int x, input int y, input logic [15:0] c);
        fb_x = 8'(x); fb_y = 8'(y); fb_color = c; fb_write = 1;
        tick();
        fb_write = 0;
    endtask

    task automatic rd_expect(input int x, input int y, input logic [15:0] c);
        disp_x = 8'(x); disp_y = 8'(y); disp_req = 1;
        tick();
        disp_req = 0;
        chk("rd_latency_n1", disp_valid, 1'b0);
        tick();
        chk("rd_valid_n2", disp_valid, 1'b1);
        chk("rd_color_n2", disp_color, c);
        tick();
        chk("rd_hold_valid", disp_valid, 1'b0);
        chk("rd_hold_color", disp_color, c);
    endtask

    function automatic logic [7:0] pick_x();
        case ($urandom_range(0, 3))
            0: return 8'($urandom_range(0, 5));
            1: return 8'($urandom_range(155, 165));
            2: return 8'($urandom_range(0, 255));
            default: return 8'($urandom_range(0, 2));
        endcase
    endfunction

    function automatic logic [7:0] pick_y();
        case ($urandom_range(0, 3))
            0: return 8'($urandom_range(0, 3));
            1: return 8'($urandom_range(116, 124));
            2: return 8'($urandom_range(0, 255));
            default: return 8'($urandom_range(0, 1));
        endcase
    endfunction

    initial begin
        rstn = 0;
        repeat (3) tick();
        chk("reset_front_sel", front_sel, 1'b0);
        chk("reset_pending", swap_pending, 1'b0);
        chk("reset_done", swap_done, 1'b0);
        chk("reset_valid", disp_valid, 1'b0);
        chk("reset_color", disp_color, 16'h0000);
        rstn = 1;
        tick();

        wr(5, 7, 16'hF801);
        wr(0, 1, 16'h1234);
        wr(159, 0, 16'h5678);
        wr(160, 0, 16'hFFFF);
        repeat (2) tick();

        ctrl_swap = 1;
        tick();
        chk("pend_set", swap_pending, 1'b1);
        chk("pend_front", front_sel, 1'b0);
        ctrl_swap = 0;
        repeat (2) tick();
        ctrl_swap = 1;
        tick();
        ctrl_swap = 0;
        tick();
        chk("pend_still_front", front_sel, 1'b0);
        disp_vblank = 1;
        tick();
        chk("swap_front", front_sel, 1'b1);
        chk("swap_done_pulse", swap_done, 1'b1);
        chk("swap_pend_clr", swap_pending, 1'b0);
        tick();
        chk("swap_done_single", swap_done, 1'b0);
        disp_vblank = 0;
        repeat (3) tick();
        disp_vblank = 1;
        tick();
        disp_vblank = 0;
        tick();
        chk("no_second_swap", front_sel, 1'b1);

        rd_expect(5, 7, 16'hF801);
        rd_expect(0, 1, 16'h1234);
        rd_expect(159, 0, 16'h5678);
        rd_expect(200, 3, 16'h0000);

        ctrl_swap = 1; disp_vblank = 1;
        tick();
        chk("same_cycle_front", front_sel, 1'b0);
        chk("same_cycle_done", swap_done, 1'b1);
        chk("same_cycle_pend", swap_pending, 1'b0);
        ctrl_swap = 0; disp_vblank = 0;
        tick();
        chk("same_cycle_pend2", swap_pending, 1'b0);

        ctrl_swap = 1;
        tick();
        ctrl_swap = 0;
        tick();
        disp_x = 8'd10; disp_y = 8'd20; disp_req = 1;
        fb_x = 8'd10; fb_y = 8'd20; fb_color = 16'hAAAA; fb_write = 1; disp_vblank = 1;
        tick();
        fb_x = 8'd11; fb_color = 16'hBBBB;
        tick();
        fb_write = 0;
        repeat (3) tick();
        disp_req = 0; disp_vblank = 0;
        repeat (2) tick();
        chk("b2b_front", front_sel, 1'b1);
        rd_expect(10, 20, 16'hAAAA);
        ctrl_swap = 1;
        tick();
        ctrl_swap = 0; disp_vblank = 1;
        tick();
        disp_vblank = 0;
        tick();
        chk("b2b_front2", front_sel, 1'b0);
        rd_expect(11, 20, 16'hBBBB);

        for (int i = 0; i < 4000; i++) begin
            rstn = ($urandom_range(0, 299) != 0);
            fb_write = $urandom_range(0, 1) == 1;
            fb_x = pick_x(); fb_y = pick_y();
            fb_color = 16'($urandom);
            if ($urandom_range(0, 19) == 0) ctrl_swap = ~ctrl_swap;
            if ($urandom_range(0, 15) == 0) disp_vblank = ~disp_vblank;
            disp_req = $urandom_range(0, 9) < 6;
            disp_x = pick_x(); disp_y = pick_y();
            tick();
        end
        rstn = 1; fb_write = 0; disp_req = 0; ctrl_swap = 0; disp_vblank = 0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
